// File: rtl/m_memdump.sv
// Memory readback unit: reads a block of 32-bit words from a sync-read port and sends them out as UART 8N1, LSB byte first.
// Optional macro MEMDUMP_CHECKSUM_EN appends one XOR-of-all-bytes checksum byte before DONE.
module m_memdump #(
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic              w_clk,
    input  logic              w_rst_n,
    input  logic              w_start,
    input  logic [ADDR_W-1:0] w_base,
    input  logic [ADDR_W:0]   w_count,
    output logic [ADDR_W-1:0] r_mem_addr,
    input  logic [31:0]       w_mem_rdata,
    output logic              r_txd,
    output logic              r_busy,
    output logic              r_done
);
    localparam int unsigned CNT_W  = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned WCNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_LAT, S_START, S_DATA, S_STOP, S_DONE} state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   bit_cnt, bit_cnt_nx;
    logic [2:0]         bit_idx, bit_idx_nx;
    logic [2:0]         bit_idx_inc;
    logic [1:0]         byte_idx, byte_idx_nx;
    logic [WCNT_W-1:0]  words_left, words_left_nx;
    logic [31:0]        shift, shift_nx;
    logic [ADDR_W-1:0]  mem_addr_nx;
    logic               txd_nx, busy_nx, done_nx;
    logic               bit_end;
`ifdef MEMDUMP_CHECKSUM_EN
    logic [7:0]         cks, cks_nx;
    logic               cks_phase, cks_phase_nx;
`endif

    // State and registered outputs
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            byte_idx   <= '0;
            words_left <= '0;
            shift      <= '0;
            r_mem_addr <= '0;
            r_txd      <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef MEMDUMP_CHECKSUM_EN
            cks        <= '0;
            cks_phase  <= 1'b0;
`endif
        end else begin
            state      <= state_nx;
            bit_cnt    <= bit_cnt_nx;
            bit_idx    <= bit_idx_nx;
            byte_idx   <= byte_idx_nx;
            words_left <= words_left_nx;
            shift      <= shift_nx;
            r_mem_addr <= mem_addr_nx;
            r_txd      <= txd_nx;
            r_busy     <= busy_nx;
            r_done     <= done_nx;
`ifdef MEMDUMP_CHECKSUM_EN
            cks        <= cks_nx;
            cks_phase  <= cks_phase_nx;
`endif
        end
    end

    assign bit_end     = (bit_cnt == BIT_LAST);
    assign bit_idx_inc = bit_idx + 3'd1;

    // Next-state and next-output logic; txd is computed for the state being entered
    always_comb begin
        state_nx      = state;
        bit_cnt_nx    = bit_cnt;
        bit_idx_nx    = bit_idx;
        byte_idx_nx   = byte_idx;
        words_left_nx = words_left;
        shift_nx      = shift;
        mem_addr_nx   = r_mem_addr;
        txd_nx        = 1'b1;
        busy_nx       = r_busy;
        done_nx       = 1'b0;
`ifdef MEMDUMP_CHECKSUM_EN
        cks_nx        = cks;
        cks_phase_nx  = cks_phase;
`endif
        unique case (state)
            S_IDLE: begin
                if (w_start) begin
                    words_left_nx = w_count;
`ifdef MEMDUMP_CHECKSUM_EN
                    cks_nx        = '0;
`endif
                    if (w_count == '0) begin
                        state_nx = S_DONE;
                        done_nx  = 1'b1;
                    end else begin
                        mem_addr_nx = w_base;
                        busy_nx     = 1'b1;
                        state_nx    = S_RD;
                    end
                end
            end
            S_RD: state_nx = S_LAT;
            S_LAT: begin
                shift_nx    = w_mem_rdata;
                byte_idx_nx = '0;
                bit_cnt_nx  = '0;
                txd_nx      = 1'b0;
                state_nx    = S_START;
`ifdef MEMDUMP_CHECKSUM_EN
                cks_nx = cks ^ w_mem_rdata[7:0] ^ w_mem_rdata[15:8]
                             ^ w_mem_rdata[23:16] ^ w_mem_rdata[31:24];
`endif
            end
            S_START: begin
                txd_nx = 1'b0;
                if (bit_end) begin
                    bit_cnt_nx = '0;
                    bit_idx_nx = '0;
                    txd_nx     = shift[0];
                    state_nx   = S_DATA;
                end else begin
                    bit_cnt_nx = bit_cnt + CNT_W'(1);
                end
            end
            S_DATA: begin
                txd_nx = shift[bit_idx];
                if (bit_end) begin
                    bit_cnt_nx = '0;
                    if (bit_idx == 3'd7) begin
                        txd_nx   = 1'b1;
                        state_nx = S_STOP;
                    end else begin
                        bit_idx_nx = bit_idx_inc;
                        txd_nx     = shift[bit_idx_inc];
                    end
                end else begin
                    bit_cnt_nx = bit_cnt + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    bit_cnt_nx = '0;
`ifdef MEMDUMP_CHECKSUM_EN
                    if (cks_phase) begin
                        state_nx = S_DONE;
                        done_nx  = 1'b1;
                    end else
`endif
                    if (byte_idx != 2'd3) begin
                        byte_idx_nx = byte_idx + 2'd1;
                        shift_nx    = {8'h00, shift[31:8]};
                        txd_nx      = 1'b0;
                        state_nx    = S_START;
                    end else if (words_left > WCNT_W'(1)) begin
                        words_left_nx = words_left - WCNT_W'(1);
                        mem_addr_nx   = r_mem_addr + ADDR_W'(1);
                        state_nx      = S_RD;
                    end else begin
`ifdef MEMDUMP_CHECKSUM_EN
                        cks_phase_nx = 1'b1;
                        shift_nx     = {24'h000000, cks};
                        txd_nx       = 1'b0;
                        state_nx     = S_START;
`else
                        state_nx = S_DONE;
                        done_nx  = 1'b1;
`endif
                    end
                end else begin
                    bit_cnt_nx = bit_cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                busy_nx  = 1'b0;
                state_nx = S_IDLE;
`ifdef MEMDUMP_CHECKSUM_EN
                cks_phase_nx = 1'b0;
`endif
            end
            default: state_nx = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_m_memdump.sv
// Scoreboard bench for m_memdump: expected bytes are queued per dump, a UART receiver pops and compares.
module tb_m_memdump;
    localparam int ADDR_W = 5;
    localparam int C      = 4;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int CW     = ADDR_W + 1;
`ifdef MEMDUMP_CHECKSUM_EN
    localparam bit CKS = 1'b1;
`else
    localparam bit CKS = 1'b0;
`endif

    logic              w_clk, w_rst_n, w_start;
    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W:0]   w_count;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       w_mem_rdata;
    logic              r_txd, r_busy, r_done;

    logic [31:0] mem [DEPTH];
    logic [7:0]  exp_q [$];
    int errors = 0;
    int checks = 0;

    m_memdump #(.ADDR_W(ADDR_W), .CLKS_PER_BIT(C)) dut (
        .w_clk(w_clk), .w_rst_n(w_rst_n), .w_start(w_start), .w_base(w_base),
        .w_count(w_count), .r_mem_addr(r_mem_addr), .w_mem_rdata(w_mem_rdata),
        .r_txd(r_txd), .r_busy(r_busy), .r_done(r_done)
    );

    initial begin
        w_clk = 1'b0;
        forever #5 w_clk = ~w_clk;
    end

    // Synchronous-read memory: data for the address of the previous cycle
    always @(posedge w_clk) w_mem_rdata <= mem[r_mem_addr];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // UART receiver: samples mid-bit, drops frames that a reset cut short
    initial begin : uart_mon
        logic [7:0] rx;
        logic       stop_v;
        bit         ab;
        forever begin
            @(negedge w_clk);
            if (w_rst_n && r_txd === 1'b0) begin
                ab = 1'b0;
                repeat (C / 2) begin @(negedge w_clk); if (!w_rst_n) ab = 1'b1; end
                for (int j = 0; j < 8; j++) begin
                    repeat (C) begin @(negedge w_clk); if (!w_rst_n) ab = 1'b1; end
                    rx[j] = r_txd;
                end
                repeat (C) begin @(negedge w_clk); if (!w_rst_n) ab = 1'b1; end
                stop_v = r_txd;
                if (!ab) begin
                    chk("stop_bit", 64'(stop_v), 64'd1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rx_byte: got %02h, no byte expected", rx);
                    end else begin
                        chk("rx_byte", 64'(rx), 64'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    // One dump: queue expected bytes, start, then watch busy/done/address timing
    task automatic dump(input int base, input int cnt, input bit repulse);
        logic [31:0]       w;
        logic [7:0]        acc;
        logic [ADDR_W-1:0] last;
        int                addrs [$];
        int                n, exp_n;
        bit                got;
        acc = 8'h00;
        for (int i = 0; i < cnt; i++) begin
            w = mem[(base + i) % DEPTH];
            for (int b = 0; b < 4; b++) begin
                exp_q.push_back(w[8*b +: 8]);
                acc ^= w[8*b +: 8];
            end
        end
        if (CKS && cnt > 0) exp_q.push_back(acc);
        // done pulse arrives cnt*(2+40C) edges after the accepting edge (+ one frame for checksum)
        exp_n = 1 + cnt * (2 + 40 * C) + ((CKS && cnt > 0) ? 10 * C : 0);
        @(negedge w_clk);
        w_base  = ADDR_W'(base);
        w_count = CW'(cnt);
        w_start = 1'b1;
        @(negedge w_clk);
        w_start = 1'b0;
        n   = 1;
        got = 1'b0;
        last = '0;
        chk("busy_rise", 64'(r_busy), 64'(cnt > 0));
        while (n <= exp_n + 40 && !got) begin
            if (cnt > 0 && r_busy && (n == 1 || r_mem_addr != last)) begin
                addrs.push_back(int'(r_mem_addr));
                last = r_mem_addr;
            end
            if (repulse && n == 50) begin
                w_start = 1'b1;
                w_base  = ADDR_W'(7);
                w_count = CW'(3);
            end
            if (repulse && n == 51) w_start = 1'b0;
            if (r_done) got = 1'b1;
            else begin
                @(negedge w_clk);
                n++;
            end
        end
        chk("done_cycle", got ? 64'(n) : 64'hFFFF_FFFF, 64'(exp_n));
        if (got) begin
            chk("busy_at_done", 64'(r_busy), 64'(cnt > 0));
            @(negedge w_clk);
            chk("done_width", 64'(r_done), 64'd0);
            chk("busy_after_done", 64'(r_busy), 64'd0);
        end
        chk("addr_count", 64'(addrs.size()), 64'(cnt));
        if (addrs.size() == cnt)
            for (int i = 0; i < cnt; i++) chk("addr_seq", 64'(addrs[i]), 64'((base + i) % DEPTH));
        chk("bytes_left", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        w_rst_n = 1'b0;
        w_start = 1'b0;
        w_base  = '0;
        w_count = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        #12;
        chk("rst_txd", 64'(r_txd), 64'd1);
        chk("rst_busy", 64'(r_busy), 64'd0);
        chk("rst_done", 64'(r_done), 64'd0);
        chk("rst_addr", 64'(r_mem_addr), 64'd0);
        repeat (2) @(negedge w_clk);
        w_rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge w_clk);
            chk("idle_outputs", {61'd0, r_txd, r_busy, r_done}, 64'b100);
        end

        mem[3] = 32'h12345678;
        dump(3, 1, 1'b0);
        mem[31] = 32'h000000AA;
        mem[0]  = 32'h000000BB;
        dump(31, 2, 1'b0);
        dump(5, 0, 1'b0);
        dump(3, 2, 1'b1);

        // Reset asserted between edges during a data bit
        @(negedge w_clk);
        w_base  = ADDR_W'(3);
        w_count = CW'(1);
        w_start = 1'b1;
        @(negedge w_clk);
        w_start = 1'b0;
        repeat (20) @(negedge w_clk);
        @(posedge w_clk);
        #3 w_rst_n = 1'b0;
        #1;
        chk("midrst_txd", 64'(r_txd), 64'd1);
        chk("midrst_busy", 64'(r_busy), 64'd0);
        chk("midrst_addr", 64'(r_mem_addr), 64'd0);
        repeat (6) @(negedge w_clk);
        w_rst_n = 1'b1;
        repeat (50) @(negedge w_clk);
        chk("post_rst_txd", 64'(r_txd), 64'd1);
        exp_q.delete();
        dump(3, 1, 1'b0);

        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
            dump($urandom_range(0, DEPTH - 1), $urandom_range(0, 4), k[0]);
        end
        dump($urandom_range(0, DEPTH - 1), DEPTH, 1'b0);

        repeat (10) @(negedge w_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/m_memdump.md
Name: m_memdump

Overview:
- Memory readback unit: reads a block of 32-bit words from a synchronous-read memory port (data memory of m_proc5, or a second port of m_imem) and serializes them out of a UART 8N1 transmitter.
- It is the readback counterpart of direct memory preloading. The bench or host gets the memory contents back through one pin instead of through hierarchical peeks.
- Sits beside the processor, on the memory's spare read port.

Parameters:
- ADDR_W, 5, word-address width; memory depth is 2^ADDR_W words.
- CLKS_PER_BIT, 4, clock cycles per UART bit (must be >= 2).

Ports:
- w_clk  in  1  clock, all state updates on rising edge.
- w_rst_n  in  1  asynchronous active-low reset.
- w_start  in  1  one-cycle request to begin a dump; sampled only in IDLE.
- w_base  in  ADDR_W  first word address, latched with w_start.
- w_count  in  ADDR_W+1  number of words to dump (0 .. 2^ADDR_W), latched with w_start.
- r_mem_addr  out  ADDR_W  memory read address; memory returns data one cycle later.
- w_mem_rdata  in  32  read data for the address presented in the previous cycle.
- r_txd  out  1  serial output, idle high.
- r_busy  out  1  high from the cycle after w_start is accepted until dump end.
- r_done  out  1  one-cycle pulse when the dump completes.

Behaviour:
- Reset is asynchronous and active-low on w_rst_n; every flop clears immediately, with no clock edge needed.
  - Reset values: r_txd=1, r_busy=0, r_done=0, r_mem_addr=0, state=IDLE.
  - Reset mid-frame aborts the dump; r_txd returns high at once. No partial byte is resumed.
- States: IDLE, RD, LAT, START, DATA, STOP, DONE.
- IDLE:
  - w_start=1 latches base and count.
  - If count=0: go to DONE.
  - Otherwise: r_mem_addr<=base, r_busy<=1, go to RD.
- RD: one cycle while the memory read is in flight; go to LAT.
- LAT: latch w_mem_rdata into a 32-bit shift word; byte index=0; go to START.
- START: r_txd=0 for CLKS_PER_BIT cycles. The first start bit drives low 3 cycles after the w_start cycle.
- DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles.
- STOP: r_txd=1 for CLKS_PER_BIT cycles.
  - If byte index < 3: increment the index, go to START.
  - Else if words remaining > 1: decrement, r_mem_addr<=r_mem_addr+1 (mod 2^ADDR_W), go to RD.
  - Else: go to DONE.
- Byte order is little-endian: bits [7:0] first, [31:24] last.
- DONE: r_done=1 for exactly one cycle, r_busy<=0, return to IDLE.
- Address wraps modulo 2^ADDR_W; count=2^ADDR_W dumps all of memory exactly once.
- w_start while busy is ignored; latched base and count are unaffected by input changes mid-dump.
- w_start in the same cycle as DONE is ignored. A new start is accepted from the next cycle.
- Bit timing: a single counter of width clog2(CLKS_PER_BIT) reloads at each bit boundary. There is no gap between a stop bit and the next start bit within a dump.
- Frame length: 10*CLKS_PER_BIT cycles per byte; one dump of N words lasts N*(2+40*CLKS_PER_BIT) cycles plus the DONE cycle.

Optional Feature:
- Macro: MEMDUMP_CHECKSUM_EN.
- Defined: after the last word's final stop bit, one extra 8N1 byte is sent before DONE. Its value is the XOR of all dumped bytes.
  - The accumulator clears on accepted w_start.
  - For count=0 no checksum byte is sent.
- Undefined: no checksum logic or state; behaviour exactly as above.

Test Plan:
- Reset then idle 20 cycles -> r_txd=1, r_busy=0, r_done=0 throughout.
- mem[3]=32'h12345678, base=3, count=1, CLKS_PER_BIT=4 -> bytes 78,56,34,12 received in that order; r_done pulses at cycle 162 after start; r_busy low the cycle after.
- Wrap: ADDR_W=5, base=31, count=2, mem[31]=32'h000000AA, mem[0]=32'h000000BB -> bytes AA,00,00,00,BB,00,00,00; r_mem_addr shows 31 then 0.
- count=0 -> r_done pulses 1 cycle after start; r_txd never leaves 1.
- w_start re-pulsed mid-dump with base=7 -> ignored; output matches the original dump exactly.
- Assert w_rst_n=0 during a DATA bit, mid-cycle -> r_txd=1 and r_busy=0 before the next edge. With MEMDUMP_CHECKSUM_EN, the word 32'h12345678 yields a trailing byte 08.
